// File: rtl/serdes_reset_sequencer_if.sv
// Status/control bundle between the LVDS receive front end and its reset sequencer.
// The inputs are asynchronous to serdes_clkdiv; the outputs are registered in that domain.
interface serdes_reset_sequencer_if;
    logic       locked;
    logic       idlyctrl_rdy;
    logic       idlyctrl_rst;
    logic       serdes_rst;
    logic       ready;
    logic [2:0] state;
    logic [7:0] retry_cnt;

    modport slave  (input  locked, idlyctrl_rdy,
                    output idlyctrl_rst, serdes_rst, ready, state, retry_cnt);
    modport master (output locked, idlyctrl_rdy,
                    input  idlyctrl_rst, serdes_rst, ready, state, retry_cnt);
endinterface

// File: rtl/serdes_reset_sequencer.sv
// Sequences IDELAYCTRL and ISERDES resets after MMCM lock, all in the serdes_clkdiv domain.
// Re-runs automatically on loss of lock or loss of IDELAYCTRL ready.
module serdes_reset_sequencer #(
    parameter int SYNC_STAGES        = 3,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int DLYCTRL_RST_CYCLES = 8,
    parameter int RDY_TIMEOUT        = 4096,
    parameter int SERDES_RST_CYCLES  = 16,
    parameter int CNT_W              = 16
) (
    input  logic                     serdes_clkdiv,
    input  logic                     reset_n,
    serdes_reset_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        WAIT_LOCK   = 3'd0,
        LOCK_STABLE = 3'd1,
        DLYCTRL_RST = 3'd2,
        WAIT_RDY    = 3'd3,
        SERDES_RST  = 3'd4,
        READY       = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] L_LOCK_END = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_DLY_END  = CNT_W'(DLYCTRL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_RDY_END  = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_SER_END  = CNT_W'(SERDES_RST_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_lock_sync, r_rdy_sync;
    state_t                 r_state, w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [7:0]             r_retry;
    logic                   r_idly_rst, r_serdes_rst, r_ready;
    logic                   w_locked_s, w_rdy_s, w_retry;
    logic                   w_idly_rst, w_serdes_rst, w_ready;

    assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
    assign w_rdy_s    = r_rdy_sync[SYNC_STAGES-1];

    always_ff @(posedge serdes_clkdiv or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_sync <= '0;
            r_rdy_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], bus.locked};
            r_rdy_sync  <= {r_rdy_sync[SYNC_STAGES-2:0], bus.idlyctrl_rdy};
        end
    end

    // Lock loss pre-empts every other transition, including from illegal codes.
    always_comb begin
        w_next  = r_state;
        w_retry = 1'b0;
        if (r_state != WAIT_LOCK && !w_locked_s) begin
            w_next = WAIT_LOCK;
        end else begin
            case (r_state)
                WAIT_LOCK:   if (w_locked_s) w_next = LOCK_STABLE;
                LOCK_STABLE: if (r_cnt == L_LOCK_END) w_next = DLYCTRL_RST;
                DLYCTRL_RST: if (r_cnt == L_DLY_END) w_next = WAIT_RDY;
                WAIT_RDY: begin
                    if (w_rdy_s) begin
                        w_next = SERDES_RST;
                    end else if (r_cnt == L_RDY_END) begin
                        w_next  = DLYCTRL_RST;
                        w_retry = 1'b1;
                    end
                end
                SERDES_RST: begin
                    if (!w_rdy_s) begin
                        w_next  = DLYCTRL_RST;
                        w_retry = 1'b1;
                    end else if (r_cnt == L_SER_END) begin
                        w_next = READY;
                    end
                end
                READY: begin
                    if (!w_rdy_s) begin
                        w_next  = DLYCTRL_RST;
                        w_retry = 1'b1;
                    end
                end
                default: w_next = WAIT_LOCK;
            endcase
        end
    end

    always_comb begin
        w_idly_rst   = 1'b1;
        w_serdes_rst = 1'b1;
        w_ready      = 1'b0;
        case (w_next)
            WAIT_RDY, SERDES_RST: w_idly_rst = 1'b0;
            READY: begin
                w_idly_rst   = 1'b0;
                w_serdes_rst = 1'b0;
                w_ready      = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs are a registered decode of the next state so they switch with the state code.
    always_ff @(posedge serdes_clkdiv or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_retry      <= '0;
            r_idly_rst   <= 1'b1;
            r_serdes_rst <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            if (w_retry && r_retry != 8'hFF) r_retry <= r_retry + 8'd1;
            r_idly_rst   <= w_idly_rst;
            r_serdes_rst <= w_serdes_rst;
            r_ready      <= w_ready;
        end
    end

    assign bus.idlyctrl_rst = r_idly_rst;
    assign bus.serdes_rst   = r_serdes_rst;
    assign bus.ready        = r_ready;
    assign bus.state        = r_state;
    assign bus.retry_cnt    = r_retry;
endmodule

// File: tb/tb_serdes_reset_sequencer.sv
// Directed bench for serdes_reset_sequencer with short dwell parameters.
module tb_serdes_reset_sequencer;
    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    serdes_reset_sequencer_if bus();

    serdes_reset_sequencer #(
        .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(16), .DLYCTRL_RST_CYCLES(4),
        .RDY_TIMEOUT(32), .SERDES_RST_CYCLES(8), .CNT_W(16)
    ) dut (
        .serdes_clkdiv(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input string tag, input logic [2:0] s, input int budget);
        int n = 0;
        while (bus.state !== s && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.state), 32'(s));
    endtask

    // Cycles spent in the current state until it changes.
    task automatic dwell(input logic [2:0] s, output int n);
        n = 0;
        while (bus.state === s && n < 5000) begin
            step();
            n++;
        end
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input logic ir,
                            input logic sr, input logic rd);
        chk({tag, "_state"}, 32'(bus.state), 32'(st));
        chk({tag, "_idly"},  32'(bus.idlyctrl_rst), 32'(ir));
        chk({tag, "_ser"},   32'(bus.serdes_rst), 32'(sr));
        chk({tag, "_rdy"},   32'(bus.ready), 32'(rd));
    endtask

    initial begin
        int n;
        reset_n          = 1'b1;
        bus.locked       = 1'b0;
        bus.idlyctrl_rdy = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk_outs("rst", 3'd0, 1'b1, 1'b1, 1'b0);
        chk("rst_retry", 32'(bus.retry_cnt), 32'd0);
        bus.locked = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Nominal bring-up
        wait_for("nom_s1", 3'd1, 10);
        dwell(3'd1, n); chk("nom_dwell1", 32'(n), 32'd16);
        chk_outs("nom_s2", 3'd2, 1'b1, 1'b1, 1'b0);
        dwell(3'd2, n); chk("nom_dwell2", 32'(n), 32'd4);
        chk_outs("nom_s3", 3'd3, 1'b0, 1'b1, 1'b0);
        repeat (5) step();
        bus.idlyctrl_rdy = 1'b1;
        dwell(3'd3, n); chk("nom_rdy_lat", 32'(n), 32'd3);
        chk_outs("nom_s4", 3'd4, 1'b0, 1'b1, 1'b0);
        dwell(3'd4, n); chk("nom_dwell4", 32'(n), 32'd8);
        chk_outs("nom_s5", 3'd5, 1'b0, 1'b0, 1'b1);
        chk("nom_retry", 32'(bus.retry_cnt), 32'd0);

        // RDY loss in READY
        bus.idlyctrl_rdy = 1'b0;
        dwell(3'd5, n); chk("rdyloss_lat", 32'(n), 32'd3);
        chk_outs("rdyloss", 3'd2, 1'b1, 1'b1, 1'b0);
        chk("rdyloss_retry", 32'(bus.retry_cnt), 32'd1);
        bus.idlyctrl_rdy = 1'b1;
        dwell(3'd2, n); chk("rdyloss_dwell2", 32'(n), 32'd4);
        wait_for("rdyloss_back", 3'd5, 20);

        // Lock loss in READY
        bus.locked = 1'b0;
        dwell(3'd5, n); chk("lockloss_lat", 32'(n), 32'd3);
        chk_outs("lockloss", 3'd0, 1'b1, 1'b1, 1'b0);
        chk("lockloss_retry", 32'(bus.retry_cnt), 32'd1);

        // Lock glitch during LOCK_STABLE
        bus.idlyctrl_rdy = 1'b0;
        bus.locked = 1'b1;
        wait_for("glitch_s1", 3'd1, 10);
        repeat (10) step();
        bus.locked = 1'b0;
        repeat (3) step();
        chk("glitch_s0", 32'(bus.state), 32'd0);
        bus.locked = 1'b1;
        wait_for("glitch_s1b", 3'd1, 10);
        dwell(3'd1, n); chk("glitch_dwell1", 32'(n), 32'd16);

        // RDY timeout
        chk("to_s2", 32'(bus.state), 32'd2);
        dwell(3'd2, n);
        chk_outs("to_s3", 3'd3, 1'b0, 1'b1, 1'b0);
        dwell(3'd3, n); chk("to_dwell3", 32'(n), 32'd32);
        chk_outs("to_retry_s2", 3'd2, 1'b1, 1'b1, 1'b0);
        chk("to_retry1", 32'(bus.retry_cnt), 32'd2);
        dwell(3'd2, n); chk("to_dwell2", 32'(n), 32'd4);
        for (int i = 0; i < 300; i++) begin
            wait_for("to_loop3", 3'd3, 10);
            wait_for("to_loop2", 3'd2, 40);
        end
        chk("to_sat", 32'(bus.retry_cnt), 32'd255);
        wait_for("to_sat3", 3'd3, 10);
        wait_for("to_sat2", 3'd2, 40);
        chk("to_sat_hold", 32'(bus.retry_cnt), 32'd255);

        // Async reset mid-WAIT_RDY
        wait_for("ar_s3", 3'd3, 10);
        repeat (5) step();
        #2 reset_n = 1'b0;
        #1;
        chk_outs("ar", 3'd0, 1'b1, 1'b1, 1'b0);
        chk("ar_retry", 32'(bus.retry_cnt), 32'd0);
        #1 reset_n = 1'b1;
        step();
        chk("ar_restart_s0", 32'(bus.state), 32'd0);
        wait_for("ar_restart_s1", 3'd1, 10);
        chk("ar_restart_retry", 32'(bus.retry_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
